relu_quant_packer: RTL and testbench

- Downstream consumer of the layer_2 neuron output.
- Takes a serial stream of signed 17-bit pre-activations and adds a per-sample signed bias.
- Applies ReLU, arithmetic right-shift requantization and saturation to 12 bits.
- Packs every 4 consecutive results into a 4-lane vector (out1..out4), presented with a valid/ready handshake to feed the next 4-input layer.

---
 rtl/relu_quant_packer.sv | 120 ++++++++++++
 tb/tb_relu_quant_packer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_quant_packer.sv
// relu_quant_packer: bias add, ReLU, shift requantization and 12-bit saturation
// of a serial pre-activation stream, packed four at a time into a lane vector
// with a valid/ready handshake toward the next layer.
module relu_quant_packer #(
  parameter int unsigned SHIFT = 4,
  parameter int unsigned SAT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [16:0] in_data,
  input  logic signed [7:0]  in_bias,
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [11:0] out1,
  output logic signed [11:0] out2,
  output logic signed [11:0] out3,
  output logic signed [11:0] out4,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SAT_W-1:0]   sat_count
);

  logic signed [17:0] a_sum_q;
  logic               a_valid_q;
  logic [1:0]         cnt_q;
  logic [11:0]        lane0_q, lane1_q, lane2_q;

  logic signed [17:0] r;
  logic [11:0]        q;
  logic               sat;
  logic               slot_free;
  logic               a_adv;
  logic               in_xfer;
  logic               emit;

  // Stage B: ReLU, requantize, clamp to the positive 12-bit range.
  always_comb begin
    r = '0;
    if (!a_sum_q[17]) begin
      r = a_sum_q >>> SHIFT;
    end
    sat = (r > 18'sd2047);
    q   = sat ? 12'd2047 : r[11:0];
  end

  // The 4th item of a group can only leave stage A when the output slot frees up.
  assign slot_free = !out_valid || out_ready;
  assign a_adv     = a_valid_q && ((cnt_q != 2'd3) || slot_free);
  assign in_ready  = !a_valid_q || a_adv;
  assign in_xfer   = in_valid && in_ready;
  assign emit      = a_adv && (cnt_q == 2'd3);

  // Stage A: register the biased sum; refill and drain may coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sum_q   <= '0;
      a_valid_q <= 1'b0;
    end else if (in_xfer) begin
      a_sum_q   <= {in_data[16], in_data} + {{10{in_bias[7]}}, in_bias};
      a_valid_q <= 1'b1;
    end else if (a_adv) begin
      a_valid_q <= 1'b0;
    end
  end

  // Collection lanes: the first three items of a group wait here.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      lane0_q <= '0;
      lane1_q <= '0;
      lane2_q <= '0;
    end else if (a_adv) begin
      case (cnt_q)
        2'd0: begin
          lane0_q <= q;
          cnt_q   <= 2'd1;
        end
        2'd1: begin
          lane1_q <= q;
          cnt_q   <= 2'd2;
        end
        2'd2: begin
          lane2_q <= q;
          cnt_q   <= 2'd3;
        end
        default: cnt_q <= 2'd0;
      endcase
    end
  end

  // Output vector: a reload wins over a consume in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out1      <= '0;
      out2      <= '0;
      out3      <= '0;
      out4      <= '0;
      out_valid <= 1'b0;
    end else if (emit) begin
      out1      <= lane0_q;
      out2      <= lane1_q;
      out3      <= lane2_q;
      out4      <= q;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturation event counter, sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count <= '0;
    end else if (a_adv && sat && (sat_count != {SAT_W{1'b1}})) begin
      sat_count <= sat_count + SAT_W'(1);
    end
  end

endmodule

// File: tb/tb_relu_quant_packer.sv
// Self-checking bench for relu_quant_packer: directed table groups, backpressure,
// mid-group reset, randomized traffic against an arithmetic model, and counter saturation.
module tb_relu_quant_packer;

  localparam int unsigned SHIFT = 4;
  localparam int unsigned SAT_W = 8;
  localparam int SAT_MAX = (1 << SAT_W) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [16:0] in_data;
  logic signed [7:0]  in_bias;
  logic               in_valid;
  logic               in_ready;
  logic signed [11:0] out1, out2, out3, out4;
  logic               out_valid;
  logic               out_ready;
  logic [SAT_W-1:0]   sat_count;

  relu_quant_packer #(
    .SHIFT(SHIFT),
    .SAT_W(SAT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_bias  (in_bias),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out1     (out1),
    .out2     (out2),
    .out3     (out3),
    .out4     (out4),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [16:0] d;
    logic signed [7:0]  b;
    int                 q;
    bit                 s;
  } vec_t;

  vec_t  tbl[12];
  int    total = 0;
  int    bad = 0;
  int    exp_q[$];
  int    sat_m = 0;
  int    vec_count = 0;
  bit    prev_stall = 0;
  logic [47:0] held;
  bit    done;
  logic signed [16:0] rd;
  logic signed [7:0]  rb;
  int    v0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the biased sum.
  function automatic int ref_q(input int d, input int b);
    int s;
    s = d + b;
    if (s < 0) return 0;
    s = s / (1 << SHIFT);
    return (s > 2047) ? 2047 : s;
  endfunction

  function automatic bit ref_sat(input int d, input int b);
    int s;
    s = d + b;
    return (s >= 0) && ((s / (1 << SHIFT)) > 2047);
  endfunction

  function automatic int sat_exp();
    return (sat_m > SAT_MAX) ? SAT_MAX : sat_m;
  endfunction

  // Offer one item; returns #1 after the accepting edge.
  task automatic send(input logic signed [16:0] d, input logic signed [7:0] b,
                      input int q, input bit s);
    bit ok;
    ok = 1'b0;
    in_data  = d;
    in_bias  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("in_accept", ok, 1);
    if (ok) begin
      exp_q.push_back(q);
      sat_m += s;
    end
  endtask

  task automatic run_tbl(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      send(tbl[i].d, tbl[i].b, tbl[i].q, tbl[i].s);
      if ((i - lo) % 4 == 3) begin
        check("lat_pre_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_post_valid", out_valid, 1);
      end
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  // Output monitor: each negedge with out_valid && out_ready is a transfer at the next edge.
  always @(negedge clk) begin : mon
    int e0, e1, e2, e3;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("hold_stable", {out_valid, out1, out2, out3, out4}, {1'b1, held});
      if (out_valid && out_ready) begin
        if (exp_q.size() < 4) begin
          check("vec_pending", exp_q.size(), 4);
        end else begin
          e0 = exp_q.pop_front();
          e1 = exp_q.pop_front();
          e2 = exp_q.pop_front();
          e3 = exp_q.pop_front();
          check("lane1", out1, e0);
          check("lane2", out2, e1);
          check("lane3", out3, e2);
          check("lane4", out4, e3);
          vec_count++;
        end
      end
      prev_stall = out_valid && !out_ready;
      held = {out1, out2, out3, out4};
    end
  end

  initial begin
    tbl[0]  = '{17'sd100,    8'sd0,   6,    1'b0};
    tbl[1]  = '{-17'sd50,    8'sd0,   0,    1'b0};
    tbl[2]  = '{17'sd40000,  8'sd0,   2047, 1'b1};
    tbl[3]  = '{17'sd160,    -8'sd16, 9,    1'b0};
    tbl[4]  = '{17'sd32752,  8'sd0,   2047, 1'b0};
    tbl[5]  = '{-17'sd5,     8'sd10,  0,    1'b0};
    tbl[6]  = '{-17'sd65536, 8'sd0,   0,    1'b0};
    tbl[7]  = '{17'sd65535,  8'sd127, 2047, 1'b1};
    tbl[8]  = '{17'sd16,     8'sd0,   1,    1'b0};
    tbl[9]  = '{17'sd32,     8'sd0,   2,    1'b0};
    tbl[10] = '{17'sd48,     8'sd0,   3,    1'b0};
    tbl[11] = '{17'sd64,     8'sd0,   4,    1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_bias = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_outs", {out1, out2, out3, out4}, 0);
    check("rst_sat_count", sat_count, 0);
    check("rst_in_ready", in_ready, 1);

    // Basic group, then boundary values.
    run_tbl(0, 3);
    repeat (3) @(posedge clk);
    #1;
    check("sat_after_basic", sat_count, 1);
    run_tbl(4, 7);
    repeat (3) @(posedge clk);
    #1;
    check("sat_after_bound", sat_count, 2);

    // Backpressure: 8 items with the consumer stalled.
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(17'(i * 160), 8'sd0, ref_q(i * 160, 0), ref_sat(i * 160, 0));
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_out4", out4, 40);
    repeat (3) @(posedge clk);
    #1;
    check("bp_still_stalled", in_ready, 0);
    check("bp_out1", out1, 10);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_reload_valid", out_valid, 1);
    check("bp_reload_in_ready", in_ready, 1);
    check("bp_reload_out1", out1, 50);
    drain();
    check("bp_queue_empty", exp_q.size(), 0);

    // Reset in the middle of a group.
    send(17'sd700, 8'sd0, ref_q(700, 0), 1'b0);
    send(17'sd900, 8'sd0, ref_q(900, 0), 1'b0);
    rst = 1'b1;
    exp_q.delete();
    sat_m = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_sat", sat_count, 0);
    run_tbl(8, 11);
    drain();
    check("mid_rst_queue_empty", exp_q.size(), 0);

    // Randomized traffic with random consumer stalls.
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 200; n++) begin
          rd = 17'($urandom);
          rb = 8'($urandom);
          send(rd, rb, ref_q(int'(rd), int'(rb)), ref_sat(int'(rd), int'(rb)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
    check("rand_queue_empty", exp_q.size(), 0);
    check("rand_sat_count", sat_count, sat_exp());

    // Saturation counter ceiling.
    v0 = vec_count;
    for (int n = 0; n < 300; n++) send(17'sd65535, 8'sd0, 2047, 1'b1);
    drain();
    check("satcnt_ceiling", sat_count, SAT_MAX);
    check("satcnt_model", sat_count, sat_exp());
    check("satcnt_vectors", vec_count - v0, 75);
    check("satcnt_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
